// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int   UART_DATA_BITS   = 8;
   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: TICK marks the last cycle of a bit, PRE_TICK the cycle before it.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic CLR,
   output logic TICK,
   output logic PRE_TICK
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] count;

   always_ff @(posedge CLOCK) begin
      if (RESET || CLR) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign TICK = (count == LAST);

   // A clear this cycle restarts the bit, so the next cycle cannot be its last.
   assign PRE_TICK = !(CLR || RESET) && (count == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises each as a UART frame on TX.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic                      ENABLE,
   input  logic                      FIFO_EMPTY_N,
   input  logic [UART_DATA_BITS-1:0] FIFO_DATA,
   output logic                      FIFO_READ,
   output logic                      TX,
   output logic                      BUSY,
   output logic                      FRAME_DONE
);

   localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

   tx_state_t                 state;
   tx_state_t                 state_next;
   logic                      tick;
   logic                      pre_tick;
   logic                      timer_clr;
   logic                      stop_last;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic [UART_DATA_BITS-1:0] shift_next;
   logic                      parity_bit;
   logic                      tx_d;
   logic                      read_d;
   logic                      busy_d;
   logic                      done_d;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .CLR     (timer_clr),
      .TICK    (tick),
      .PRE_TICK(pre_tick)
   );

   assign timer_clr = (state_next != state);

   // bit_idx doubles as the stop-bit counter while in STOP.
   assign stop_last = (STOP_BITS == 1) || bit_idx[0];

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ENABLE && FIFO_EMPTY_N) state_next = POP;
         POP:     state_next = LOAD;
         LOAD:    state_next = START;
         START:   if (tick) state_next = DATA;
         DATA:    if (tick && bit_idx == LAST_IDX) state_next = PARITY_EN ? PARITY : STOP;
         PARITY:  if (tick) state_next = STOP;
         STOP:    if (tick && stop_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      shift_next = shift_reg;
      if (state == LOAD) begin
         shift_next = FIFO_DATA;
      end else if (state == DATA && tick) begin
         shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else begin
         shift_reg <= shift_next;
         if (timer_clr) begin
            bit_idx <= '0;
         end else if (tick && (state == DATA || state == STOP)) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (state == LOAD) begin
            parity_bit <= (^FIFO_DATA) ^ PARITY_ODD;
         end
      end
   end

   // Outputs are computed for the upcoming state and registered, so they line up with it.
   always_comb begin
      tx_d = UART_IDLE_LEVEL;
      case (state_next)
         START:   tx_d = UART_START_LEVEL;
         DATA:    tx_d = shift_next[0];
         PARITY:  tx_d = parity_bit;
         default: tx_d = UART_IDLE_LEVEL;
      endcase
      read_d = (state_next == POP);
      busy_d = (state_next != IDLE);
      done_d = (state == STOP) && stop_last && pre_tick;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         TX         <= UART_IDLE_LEVEL;
         FIFO_READ  <= 1'b0;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         TX         <= tx_d;
         FIFO_READ  <= read_d;
         BUSY       <= busy_d;
         FRAME_DONE <= done_d;
      end
   end

endmodule
